// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states,
// register-address width and the per-cycle pipeline control vectors.
`timescale 1ns/1ps
package hazard_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_MEMWAIT = 2'd2,
      S_ERR     = 2'd3
   } state_t;

   // One bit per pipeline-register control line driven by the scheduler.
   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_bubble;
      logic pipe_hold;
      logic mem_wb_bubble;
   } ctrl_t;

   // Whole pipeline frozen; MEM/WB gets a bubble so nothing retires twice.
   localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                     id_ex_bubble: 1'b0, pipe_hold: 1'b1, mem_wb_bubble: 1'b1};
   // Normal advance of every stage.
   localparam ctrl_t CTRL_ADVANCE = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                      id_ex_bubble: 1'b0, pipe_hold: 1'b0, mem_wb_bubble: 1'b0};
   // Load-use: hold PC and IF/ID, inject a bubble into EX, rest advances.
   localparam ctrl_t CTRL_LOADUSE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      id_ex_bubble: 1'b1, pipe_hold: 1'b0, mem_wb_bubble: 1'b0};
   // Taken branch: redirect PC and squash the wrong-path fetch in IF/ID.
   localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                    id_ex_bubble: 1'b0, pipe_hold: 1'b0, mem_wb_bubble: 1'b0};

   // A load in EX whose result is needed by the ID instruction; x0 never hazards.
   function automatic logic is_load_use(input logic                  memread,
                                        input logic [REG_ADDR_W-1:0] rd,
                                        input logic [REG_ADDR_W-1:0] rs1,
                                        input logic [REG_ADDR_W-1:0] rs2);
      return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and synchronous clear.
`timescale 1ns/1ps
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   // Next count: clear wins, otherwise increment until all-ones and stick there.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register, asynchronously cleared by the active-low reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, data-memory wait freezes with timeout, plus performance counters.
`timescale 1ns/1ps
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  id_ex_memread_i,
   input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
   input  logic [REG_ADDR_W-1:0] if_id_rs1_i,
   input  logic [REG_ADDR_W-1:0] if_id_rs2_i,
   input  logic                  branch_taken_i,
   input  logic                  dmem_req_i,
   input  logic                  dmem_ack_i,
   output logic                  pc_write_o,
   output logic                  if_id_write_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_bubble_o,
   output logic                  pipe_hold_o,
   output logic                  mem_wb_bubble_o,
   output logic                  error_o,
   output logic [CNT_W-1:0]      lu_stall_cnt_o,
   output logic [CNT_W-1:0]      mem_stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   state_t          state_d, state_q;
   logic [TW-1:0]   tmo_d, tmo_q;
   ctrl_t           ctrl_s;
   logic            lu_inc_s;
   logic            mem_inc_s;
   logic            flush_inc_s;
   logic            mem_wait_s;
   logic            load_use_s;

   assign mem_wait_s = dmem_req_i && !dmem_ack_i;
   assign load_use_s = is_load_use(id_ex_memread_i, id_ex_rd_i, if_id_rs1_i, if_id_rs2_i);

   // Next-state, timeout count, control vector and counter strobes by priority.
   always_comb begin
      state_d     = state_q;
      tmo_d       = '0;
      ctrl_s      = CTRL_FREEZE;
      lu_inc_s    = 1'b0;
      mem_inc_s   = 1'b0;
      flush_inc_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN, S_MEMWAIT: begin
            if (mem_wait_s) begin
               ctrl_s    = CTRL_FREEZE;
               mem_inc_s = 1'b1;
               if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
                  // This wait cycle would reach the limit: give up on the request.
                  state_d = S_ERR;
                  tmo_d   = '0;
               end else begin
                  state_d = S_MEMWAIT;
                  tmo_d   = tmo_q + TW'(1);
               end
            end else begin
               // No outstanding wait (idle or ack cycle): the pipeline advances.
               state_d = S_RUN;
               tmo_d   = '0;
               if (load_use_s) begin
                  // A concurrent taken branch is dropped; it re-resolves next cycle.
                  ctrl_s   = CTRL_LOADUSE;
                  lu_inc_s = 1'b1;
               end else if (branch_taken_i) begin
                  ctrl_s      = CTRL_FLUSH;
                  flush_inc_s = 1'b1;
               end else begin
                  ctrl_s = CTRL_ADVANCE;
               end
            end
         end
         S_ERR: begin
            state_d = S_ERR;
            ctrl_s  = CTRL_FREEZE;
         end
         default: begin
            state_d = S_IDLE;
            ctrl_s  = CTRL_FREEZE;
         end
      endcase
   end

   // FSM state and memory-timeout counter registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_lu_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (lu_inc_s),
      .cnt_o (lu_stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_mem_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (mem_inc_s),
      .cnt_o (mem_stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (flush_inc_s),
      .cnt_o (flush_cnt_o)
   );

   assign pc_write_o      = ctrl_s.pc_write;
   assign if_id_write_o   = ctrl_s.if_id_write;
   assign if_id_flush_o   = ctrl_s.if_id_flush;
   assign id_ex_bubble_o  = ctrl_s.id_ex_bubble;
   assign pipe_hold_o     = ctrl_s.pipe_hold;
   assign mem_wb_bubble_o = ctrl_s.mem_wb_bubble;
   assign error_o         = (state_q == S_ERR);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=8, CNT_W=4).
`timescale 1ns/1ps
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, memread, br, req, ack;
   logic [4:0] rd, rs1, rs2;
   logic       pc_w, ifid_w, ifid_fl, idex_bub, hold, mwb_bub, err;
   logic [3:0] lu_cnt, mem_cnt, fl_cnt;
   int         total = 0;
   int         bad   = 0;

   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_wb_bubble}
   localparam logic [5:0] V_FREEZE  = 6'b000011;
   localparam logic [5:0] V_ADVANCE = 6'b110000;
   localparam logic [5:0] V_LOADUSE = 6'b000100;
   localparam logic [5:0] V_FLUSH   = 6'b111000;

   hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
      .clk_i           (clk),
      .rst_i           (rst_n),
      .start_i         (start),
      .id_ex_memread_i (memread),
      .id_ex_rd_i      (rd),
      .if_id_rs1_i     (rs1),
      .if_id_rs2_i     (rs2),
      .branch_taken_i  (br),
      .dmem_req_i      (req),
      .dmem_ack_i      (ack),
      .pc_write_o      (pc_w),
      .if_id_write_o   (ifid_w),
      .if_id_flush_o   (ifid_fl),
      .id_ex_bubble_o  (idex_bub),
      .pipe_hold_o     (hold),
      .mem_wb_bubble_o (mwb_bub),
      .error_o         (err),
      .lu_stall_cnt_o  (lu_cnt),
      .mem_stall_cnt_o (mem_cnt),
      .flush_cnt_o     (fl_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctrl(input string tag, input logic [5:0] exp);
      chk(tag, {26'd0, pc_w, ifid_w, ifid_fl, idex_bub, hold, mwb_bub}, {26'd0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; memread = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;
      rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      #2;
      chk_ctrl("reset_ctrl", V_FREEZE);
      chk("reset_err", {31'd0, err}, 32'd0);
      chk("reset_cnts", {20'd0, lu_cnt, mem_cnt, fl_cnt}, 32'd0);
      tick();
      rst_n = 1'b1;

      // Idle: start low keeps the pipeline frozen.
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_ctrl("idle_freeze", V_FREEZE);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      chk_ctrl("run_advance", V_ADVANCE);

      // Load-use beats a simultaneous taken branch.
      memread = 1'b1; rd = 5'd5; rs1 = 5'd0; rs2 = 5'd5; br = 1'b1;
      #1;
      chk_ctrl("lu_ctrl", V_LOADUSE);
      tick();
      chk("lu_cnt_1", {28'd0, lu_cnt}, 32'd1);
      chk("lu_fl_cnt_0", {28'd0, fl_cnt}, 32'd0);
      // rd = x0 never stalls.
      rd = 5'd0; rs2 = 5'd0; br = 1'b0;
      #1;
      chk_ctrl("x0_no_stall", V_ADVANCE);
      tick();
      chk("x0_lu_cnt", {28'd0, lu_cnt}, 32'd1);

      // Taken branch three cycles in a row.
      memread = 1'b0; br = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_ctrl("br_flush", V_FLUSH);
         tick();
      end
      br = 1'b0;
      chk("br_fl_cnt_3", {28'd0, fl_cnt}, 32'd3);

      // Memory wait of 4 cycles, then the ack cycle advances.
      req = 1'b1; ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_ctrl("mw_freeze", V_FREEZE);
         tick();
      end
      ack = 1'b1;
      #1;
      chk_ctrl("mw_ack_advance", V_ADVANCE);
      tick();
      req = 1'b0; ack = 1'b0;
      chk("mw_cnt_4", {28'd0, mem_cnt}, 32'd4);
      chk("mw_no_err", {31'd0, err}, 32'd0);

      // Saturation: 20 more load-use cycles from 1 stick at 15.
      memread = 1'b1; rd = 5'd3; rs1 = 5'd3; rs2 = 5'd0;
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      chk("lu_sat_15", {28'd0, lu_cnt}, 32'd15);
      memread = 1'b0;

      // Timeout: 8 unacknowledged wait cycles -> error from the 9th.
      req = 1'b1; ack = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("tmo_err_low", {31'd0, err}, 32'd0);
         chk_ctrl("tmo_freeze", V_FREEZE);
         tick();
      end
      chk("tmo_err_high", {31'd0, err}, 32'd1);
      chk("tmo_mem_cnt", {28'd0, mem_cnt}, 32'd12);
      ack = 1'b1; start = 1'b1;
      #1;
      chk_ctrl("err_freeze_ack", V_FREEZE);
      tick();
      tick();
      chk("err_sticky", {31'd0, err}, 32'd1);
      chk("err_cnt_stopped", {28'd0, mem_cnt}, 32'd12);
      chk_ctrl("err_freeze_later", V_FREEZE);

      // Asynchronous reset mid-cycle returns to idle immediately.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_err", {31'd0, err}, 32'd0);
      chk_ctrl("arst_ctrl", V_FREEZE);
      chk("arst_cnts", {20'd0, lu_cnt, mem_cnt, fl_cnt}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
